// File: rtl/tcpc_i2c_pkg.sv
// tcpc_i2c_pkg: slave FSM state type, TCPC register addresses and default 7-bit slave address
package tcpc_i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;
  localparam logic [7:0] ALERT              = 8'h10;
  localparam logic [7:0] ROLE_CONTROL       = 8'h1A;
  localparam logic [7:0] FAULT_CONTROL      = 8'h1B;
  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h60;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronises i_scl/i_sda, outputs o_scl_rise/o_scl_fall pulses, synced o_sda_s and o_start/o_stop pulses
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_sda_s,
  output logic o_start,
  output logic o_stop
);
  logic [SYNC_STAGES-1:0] r_scl, r_sda;
  logic r_scl_d, r_sda_d;
  logic w_scl_s;
  assign w_scl_s    = r_scl[SYNC_STAGES-1];
  assign o_sda_s    = r_sda[SYNC_STAGES-1];
  assign o_scl_rise = w_scl_s & ~r_scl_d;
  assign o_scl_fall = ~w_scl_s & r_scl_d;
  assign o_start    = w_scl_s & r_scl_d & r_sda_d & ~o_sda_s;
  assign o_stop     = w_scl_s & r_scl_d & ~r_sda_d & o_sda_s;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scl   <= '1;
      r_sda   <= '1;
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl   <= {r_scl[SYNC_STAGES-2:0], i_scl};
      r_sda   <= {r_sda[SYNC_STAGES-2:0], i_sda};
      r_scl_d <= w_scl_s;
      r_sda_d <= o_sda_s;
    end
  end
endmodule

// File: rtl/tcpc_i2c_slave.sv
// tcpc_i2c_slave: I2C slave with pointer/auto-increment register strobes (i_scl/i_sda_in in, o_sda_oe open-drain, o_reg_* strobe bus, o_busy)
module tcpc_i2c_slave
  import tcpc_i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enb,
  input  logic       i_scl,
  input  logic       i_sda_in,
  output logic       o_sda_oe,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_wr,
  output logic       o_reg_rd,
  input  logic [7:0] i_reg_rdata,
  output logic       o_busy
);
  state_t     r_state;
  logic [6:0] r_shift;
  logic [3:0] r_cnt;
  logic [7:0] r_addr, r_wdata;
  logic       r_sda_oe, r_wr, r_rd, r_busy, r_cap, r_rw;
  logic       w_rise, w_fall, w_sda, w_start, w_stop, w_last;
  logic [7:0] w_byte;
  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_scl      (i_scl),
    .i_sda      (i_sda_in),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall),
    .o_sda_s    (w_sda),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );
  assign w_byte = {r_shift, w_sda};
  assign w_last = w_rise && r_cnt == 4'd7;
  always_ff @(posedge i_clk) begin
    r_wr  <= 1'b0;
    r_rd  <= 1'b0;
    r_cap <= r_rd;
    if (r_wr) r_addr <= r_addr + 8'd1;
    if (i_reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_cap    <= 1'b0;
      r_rw     <= 1'b0;
    end else if (!i_enb) begin
      r_state  <= IDLE;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_cap    <= 1'b0;
    end else if (w_stop) begin
      r_state  <= IDLE;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
    end else if (w_start) begin
      r_state  <= ADDR;
      r_cnt    <= '0;
      r_sda_oe <= 1'b0;
    end else begin
      if (w_rise && (r_state == ADDR || r_state == PTR || r_state == WDATA)) begin
        r_shift <= w_byte[6:0];
        r_cnt   <= r_cnt + 4'd1;
      end
      case (r_state)
        ADDR: if (w_last) begin
          r_state <= w_byte[7:1] == SLAVE_ADDR ? ADDR_ACK : IGNORE;
          r_busy  <= w_byte[7:1] == SLAVE_ADDR;
          r_rw    <= w_byte[0];
        end
        ADDR_ACK: if (w_fall) begin
          r_sda_oe <= ~r_sda_oe;
          if (r_sda_oe) begin
            r_cnt   <= '0;
            r_state <= r_rw ? RDATA : PTR;
            r_rd    <= r_rw;
          end
        end
        PTR: if (w_last) begin
          r_addr  <= w_byte;
          r_state <= PTR_ACK;
        end
        WDATA: if (w_last) begin
          r_wdata <= w_byte;
          r_wr    <= 1'b1;
          r_state <= WDATA_ACK;
        end
        PTR_ACK, WDATA_ACK: if (w_fall) begin
          r_sda_oe <= ~r_sda_oe;
          if (r_sda_oe) begin
            r_cnt   <= '0;
            r_state <= WDATA;
          end
        end
        RDATA: if (r_cap) begin
          r_shift  <= i_reg_rdata[6:0];
          r_sda_oe <= ~i_reg_rdata[7];
        end else if (w_rise) begin
          r_cnt <= r_cnt + 4'd1;
        end else if (w_fall) begin
          r_sda_oe <= r_cnt == 4'd8 ? 1'b0 : ~r_shift[6];
          r_shift  <= {r_shift[5:0], 1'b0};
          r_state  <= r_cnt == 4'd8 ? RDATA_ACK : RDATA;
        end
        RDATA_ACK: if (w_rise) begin
          r_state <= w_sda ? IGNORE : RDATA_ACK;
          r_busy  <= ~w_sda;
          r_cnt   <= '0;
          if (!w_sda) r_addr <= r_addr + 8'd1;
        end else if (w_fall && r_cnt == 4'd0) begin
          r_rd    <= 1'b1;
          r_state <= RDATA;
        end
        default: ;
      endcase
    end
  end
  assign o_sda_oe    = r_sda_oe;
  assign o_reg_addr  = r_addr;
  assign o_reg_wdata = r_wdata;
  assign o_reg_wr    = r_wr;
  assign o_reg_rd    = r_rd;
  assign o_busy      = r_busy;
endmodule

// File: tb/tb_tcpc_i2c_slave.sv
// tb_tcpc_i2c_slave: directed I2C master transactions against tcpc_i2c_slave with immediate-assertion checks
module tb_tcpc_i2c_slave;
  import tcpc_i2c_pkg::*;
  localparam int Q = 10;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       o_sda_oe, o_reg_wr, o_reg_rd, o_busy;
  logic [7:0] o_reg_addr, o_reg_wdata;
  logic [7:0] rdata = 8'h00;
  logic [7:0] mem [256];
  logic [7:0] wr_a [$];
  logic [7:0] wr_d [$];
  logic [7:0] rd_a [$];
  int         oe_cnt = 0, busy_cnt = 0, both_cnt = 0;
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign sda_bus = m_sda & ~o_sda_oe;
  tcpc_i2c_slave dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_enb       (enb),
    .i_scl       (m_scl),
    .i_sda_in    (sda_bus),
    .o_sda_oe    (o_sda_oe),
    .o_reg_addr  (o_reg_addr),
    .o_reg_wdata (o_reg_wdata),
    .o_reg_wr    (o_reg_wr),
    .o_reg_rd    (o_reg_rd),
    .i_reg_rdata (rdata),
    .o_busy      (o_busy)
  );
  always @(posedge clk) if (o_reg_rd) rdata <= mem[o_reg_addr];
  always @(negedge clk) begin
    if (o_reg_wr) begin
      wr_a.push_back(o_reg_addr);
      wr_d.push_back(o_reg_wdata);
    end
    if (o_reg_rd) rd_a.push_back(o_reg_addr);
    if (o_sda_oe) oe_cnt++;
    if (o_busy) busy_cnt++;
    if (o_reg_wr && o_reg_rd) both_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_q;
    repeat (Q) @(negedge clk);
  endtask
  task automatic i2c_start;
    m_sda = 1'b1; wait_q;
    m_scl = 1'b1; wait_q;
    m_sda = 1'b0; wait_q;
    m_scl = 1'b0; wait_q;
  endtask
  task automatic i2c_stop;
    m_sda = 1'b0; wait_q;
    m_scl = 1'b1; wait_q;
    m_sda = 1'b1; wait_q;
  endtask
  task automatic put_bit(input logic b);
    m_sda = b; wait_q;
    m_scl = 1'b1; wait_q; wait_q;
    m_scl = 1'b0; wait_q;
  endtask
  task automatic get_bit(output logic b);
    m_sda = 1'b1; wait_q;
    m_scl = 1'b1; wait_q;
    b = sda_bus; wait_q;
    m_scl = 1'b0; wait_q;
  endtask
  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask
  task automatic rd_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~ack);
  endtask
  logic       a1, a2, a3, a4;
  logic [7:0] d1, d2;
  int         wb, rb, ob, bb;
  initial begin
    mem[ALERT] = 8'h36;
    mem[ALERT + 8'd1] = 8'h71;
    mem[ROLE_CONTROL] = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_oe", 32'(o_sda_oe), 32'h0);
    chk("rst_addr", 32'(o_reg_addr), 32'h00);
    chk("rst_wdata", 32'(o_reg_wdata), 32'h00);
    chk("rst_wr_rd", 32'({o_reg_wr, o_reg_rd}), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    @(negedge clk) rst = 1'b0;
    wait_q;
    wb = wr_a.size();
    i2c_start;
    wr_byte(8'hC0, a1); wr_byte(ROLE_CONTROL, a2); wr_byte(8'h63, a3);
    chk("t1_acks", 32'({a1, a2, a3}), 32'h7);
    chk("t1_busy_on", 32'(o_busy), 32'h1);
    i2c_stop;
    wait_q;
    chk("t1_wr_cnt", 32'(wr_a.size() - wb), 32'd1);
    chk("t1_wr_addr", 32'(wr_a[wb]), 32'h1A);
    chk("t1_wr_data", 32'(wr_d[wb]), 32'h63);
    chk("t1_busy_off", 32'(o_busy), 32'h0);
    chk("t1_ptr", 32'(o_reg_addr), 32'h1B);
    wb = wr_a.size(); ob = oe_cnt; bb = busy_cnt;
    i2c_start;
    wr_byte(8'hA0, a1); wr_byte(FAULT_CONTROL, a2); wr_byte(8'h86, a3);
    i2c_stop;
    wait_q;
    chk("t2_acks", 32'({a1, a2, a3}), 32'h0);
    chk("t2_oe_seen", 32'(oe_cnt - ob), 32'd0);
    chk("t2_wr_cnt", 32'(wr_a.size() - wb), 32'd0);
    chk("t2_busy_seen", 32'(busy_cnt - bb), 32'd0);
    wb = wr_a.size();
    i2c_start;
    wr_byte(8'hC0, a1); wr_byte(ALERT, a2); wr_byte(8'h36, a3); wr_byte(8'h71, a4);
    i2c_stop;
    wait_q;
    chk("t3_acks", 32'({a1, a2, a3, a4}), 32'hF);
    chk("t3_wr_cnt", 32'(wr_a.size() - wb), 32'd2);
    chk("t3_wr0", 32'({wr_a[wb], wr_d[wb]}), 32'h1036);
    chk("t3_wr1", 32'({wr_a[wb+1], wr_d[wb+1]}), 32'h1171);
    chk("t3_ptr", 32'(o_reg_addr), 32'h12);
    rb = rd_a.size(); wb = wr_a.size();
    i2c_start;
    wr_byte(8'hC0, a1); wr_byte(ALERT, a2);
    i2c_start;
    wr_byte(8'hC1, a3);
    chk("t4_acks", 32'({a1, a2, a3}), 32'h7);
    rd_byte(d1, 1'b1);
    rd_byte(d2, 1'b0);
    chk("t4_rd_data0", 32'(d1), 32'h36);
    chk("t4_rd_data1", 32'(d2), 32'h71);
    chk("t4_rd_cnt", 32'(rd_a.size() - rb), 32'd2);
    chk("t4_rd_addr0", 32'(rd_a[rb]), 32'h10);
    chk("t4_rd_addr1", 32'(rd_a[rb+1]), 32'h11);
    chk("t4_nack_oe", 32'(o_sda_oe), 32'h0);
    chk("t4_nack_busy", 32'(o_busy), 32'h0);
    i2c_stop;
    wait_q;
    chk("t4_wr_cnt", 32'(wr_a.size() - wb), 32'd0);
    wb = wr_a.size();
    i2c_start;
    wr_byte(8'hC0, a1); wr_byte(8'hFF, a2); wr_byte(8'hAA, a3); wr_byte(8'hBB, a4);
    i2c_stop;
    wait_q;
    chk("t5_acks", 32'({a1, a2, a3, a4}), 32'hF);
    chk("t5_wr_cnt", 32'(wr_a.size() - wb), 32'd2);
    chk("t5_wr0", 32'({wr_a[wb], wr_d[wb]}), 32'hFFAA);
    chk("t5_wr1", 32'({wr_a[wb+1], wr_d[wb+1]}), 32'h00BB);
    chk("t5_ptr", 32'(o_reg_addr), 32'h01);
    wb = wr_a.size();
    i2c_start;
    wr_byte(8'hC0, a1); wr_byte(ROLE_CONTROL, a2);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    i2c_stop;
    wait_q;
    chk("t6_partial_wr", 32'(wr_a.size() - wb), 32'd0);
    chk("t6_partial_busy", 32'(o_busy), 32'h0);
    chk("t6_partial_ptr", 32'(o_reg_addr), 32'h1A);
    i2c_start;
    wr_byte(8'hC1, a1);
    get_bit(a2); get_bit(a3); get_bit(a4);
    chk("t6_rd_bits", 32'({a1, a2, a3, a4}), 32'h8);
    chk("t6_oe_pre_rst", 32'(o_sda_oe), 32'h1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    chk("t6_rst_oe", 32'(o_sda_oe), 32'h0);
    chk("t6_rst_busy", 32'(o_busy), 32'h0);
    chk("t6_rst_addr", 32'(o_reg_addr), 32'h00);
    @(negedge clk) rst = 1'b0;
    i2c_stop;
    wait_q;
    wb = wr_a.size();
    i2c_start;
    wr_byte(8'hC0, a1); wr_byte(FAULT_CONTROL, a2); wr_byte(8'h91, a3);
    i2c_stop;
    wait_q;
    chk("t6_after_acks", 32'({a1, a2, a3}), 32'h7);
    chk("t6_after_wr_cnt", 32'(wr_a.size() - wb), 32'd1);
    chk("t6_after_wr", 32'({wr_a[wb], wr_d[wb]}), 32'h1B91);
    chk("t6_after_ptr", 32'(o_reg_addr), 32'h1C);
    chk("wr_rd_overlap", 32'(both_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
